// File: rtl/axil_memory_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axil_memory_arbiter_pkg
//   Shared definitions for the two-into-one AXI4-Lite memory arbiter:
//   FSM state encoding, upstream port identifiers and AXI response codes.
// ---------------------------------------------------------------------------
package axil_memory_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,   // waiting for a request
        ST_M_AR = 3'd1,   // driving master read address
        ST_M_R  = 3'd2,   // awaiting master read data
        ST_S_R  = 3'd3,   // returning read data upstream
        ST_M_W  = 3'd4,   // driving master write address + data
        ST_M_B  = 3'd5,   // awaiting master write response
        ST_S_B  = 3'd6    // returning write response upstream
    } state_e;

    localparam logic PORT_INSTR = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
//   Two-requester round-robin arbiter. Grant is combinational from the
//   requests and the last-grant flop; the flop only updates when the owner
//   actually accepts the granted request.
//
//   clk_i     clock
//   rst_ni    asynchronous active-low reset (last grant -> data port)
//   req_i     [0] instruction port, [1] data port
//   accept_i  grant was consumed this cycle
//   gnt_o     one-hot grant, same bit order as req_i
// ---------------------------------------------------------------------------
module rr_arbiter_2
    import axil_memory_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o = '0;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // Tie: favour whichever port did not win last time.
            2'b11:   gnt_o = (last_q == PORT_DATA) ? 2'b01 : 2'b10;
            default: gnt_o = '0;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (accept_i) begin
            last_d = gnt_o[1] ? PORT_DATA : PORT_INSTR;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= PORT_DATA;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/axil_memory_arbiter.sv
// ---------------------------------------------------------------------------
// axil_memory_arbiter
//   Serialises the CPU instruction (read-only) and data (read/write) AXI4-Lite
//   masters onto one AXI4-Lite master port toward the memory controller.
//   Round-robin between ports, read before write on the data port, and only
//   one transaction outstanding overall.
//
//   i_Clock / i_Reset_N   clock, asynchronous active-low reset
//   s_instr_axil_*        instruction port (AR/R only)
//   s_data_axil_*         data port (AR/R/AW/W/B)
//   m_axil_*              shared memory-controller port; all valid/ready and
//                         payload outputs come straight from flops
//   Upstream accept strobes (s_*ready) are combinational in IDLE only.
// ---------------------------------------------------------------------------
module axil_memory_arbiter
    import axil_memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset_N,

    input  logic [ADDR_WIDTH-1:0]     s_instr_axil_araddr,
    input  logic                      s_instr_axil_arvalid,
    output logic                      s_instr_axil_arready,
    output logic [DATA_WIDTH-1:0]     s_instr_axil_rdata,
    output logic                      s_instr_axil_rvalid,
    input  logic                      s_instr_axil_rready,

    input  logic [ADDR_WIDTH-1:0]     s_data_axil_araddr,
    input  logic                      s_data_axil_arvalid,
    output logic                      s_data_axil_arready,
    output logic [DATA_WIDTH-1:0]     s_data_axil_rdata,
    output logic                      s_data_axil_rvalid,
    input  logic                      s_data_axil_rready,
    input  logic [ADDR_WIDTH-1:0]     s_data_axil_awaddr,
    input  logic                      s_data_axil_awvalid,
    output logic                      s_data_axil_awready,
    input  logic [DATA_WIDTH-1:0]     s_data_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_data_axil_wstrb,
    input  logic                      s_data_axil_wvalid,
    output logic                      s_data_axil_wready,
    output logic [1:0]                s_data_axil_bresp,
    output logic                      s_data_axil_bvalid,
    input  logic                      s_data_axil_bready,

    output logic [ADDR_WIDTH-1:0]     m_axil_araddr,
    output logic                      m_axil_arvalid,
    input  logic                      m_axil_arready,
    input  logic [DATA_WIDTH-1:0]     m_axil_rdata,
    input  logic                      m_axil_rvalid,
    output logic                      m_axil_rready,
    output logic [ADDR_WIDTH-1:0]     m_axil_awaddr,
    output logic                      m_axil_awvalid,
    input  logic                      m_axil_awready,
    output logic [DATA_WIDTH-1:0]     m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axil_wstrb,
    output logic                      m_axil_wvalid,
    input  logic                      m_axil_wready,
    input  logic [1:0]                m_axil_bresp,
    input  logic                      m_axil_bvalid,
    output logic                      m_axil_bready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_e                  state_q,   state_d;
    logic                    port_q,    port_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q,   wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
    logic [1:0]              bresp_q,   bresp_d;
    logic                    arvalid_q, arvalid_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q,  wvalid_d;
    logic                    rready_q,  rready_d;
    logic                    bready_q,  bready_d;

    logic       is_idle;
    logic       instr_req, data_req;
    logic [1:0] req, gnt;
    logic       instr_acc, data_rd_acc, data_wr_acc, accept;

    assign is_idle   = (state_q == ST_IDLE);
    assign instr_req = s_instr_axil_arvalid;
    // A write only counts once AW and W are presented together.
    assign data_req  = s_data_axil_arvalid | (s_data_axil_awvalid & s_data_axil_wvalid);
    assign req       = is_idle ? {data_req, instr_req} : 2'b00;

    rr_arbiter_2 u_rr (
        .clk_i    (i_Clock),
        .rst_ni   (i_Reset_N),
        .req_i    (req),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    // A granted data port with both a read and a write pending takes the read.
    assign instr_acc   = gnt[0];
    assign data_rd_acc = gnt[1] &  s_data_axil_arvalid;
    assign data_wr_acc = gnt[1] & ~s_data_axil_arvalid;
    assign accept      = instr_acc | data_rd_acc | data_wr_acc;

    assign s_instr_axil_arready = instr_acc;
    assign s_data_axil_arready  = data_rd_acc;
    assign s_data_axil_awready  = data_wr_acc;
    assign s_data_axil_wready   = data_wr_acc;

    assign s_instr_axil_rdata   = rdata_q;
    assign s_data_axil_rdata    = rdata_q;
    assign s_instr_axil_rvalid  = (state_q == ST_S_R) && (port_q == PORT_INSTR);
    assign s_data_axil_rvalid   = (state_q == ST_S_R) && (port_q == PORT_DATA);
    assign s_data_axil_bvalid   = (state_q == ST_S_B);
    assign s_data_axil_bresp    = bresp_q;

    assign m_axil_araddr  = addr_q;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        bresp_d   = bresp_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        rready_d  = rready_q;
        bready_d  = bready_q;

        case (state_q)
            ST_IDLE: begin
                if (instr_acc) begin
                    port_d    = PORT_INSTR;
                    addr_d    = s_instr_axil_araddr;
                    arvalid_d = 1'b1;
                    state_d   = ST_M_AR;
                end else if (data_rd_acc) begin
                    port_d    = PORT_DATA;
                    addr_d    = s_data_axil_araddr;
                    arvalid_d = 1'b1;
                    state_d   = ST_M_AR;
                end else if (data_wr_acc) begin
                    port_d    = PORT_DATA;
                    addr_d    = s_data_axil_awaddr;
                    wdata_d   = s_data_axil_wdata;
                    wstrb_d   = s_data_axil_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = ST_M_W;
                end
            end
            ST_M_AR: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_M_R;
                end
            end
            ST_M_R: begin
                if (m_axil_rvalid) begin
                    rdata_d  = m_axil_rdata;
                    rready_d = 1'b0;
                    state_d  = ST_S_R;
                end
            end
            ST_S_R: begin
                if ((port_q == PORT_INSTR) ? s_instr_axil_rready : s_data_axil_rready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_M_W: begin
                // AW and W complete independently; leave once both are done.
                awvalid_d = awvalid_q & ~m_axil_awready;
                wvalid_d  = wvalid_q  & ~m_axil_wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_M_B;
                end
            end
            ST_M_B: begin
                if (m_axil_bvalid) begin
                    bresp_d  = m_axil_bresp;
                    bready_d = 1'b0;
                    state_d  = ST_S_B;
                end
            end
            ST_S_B: begin
                if (s_data_axil_bready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state_q   <= ST_IDLE;
            port_q    <= PORT_INSTR;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            bresp_q   <= RESP_OKAY;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rready_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            bresp_q   <= bresp_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            rready_q  <= rready_d;
            bready_q  <= bready_d;
        end
    end

endmodule

// File: tb/tb_axil_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axil_memory_arbiter
//   Directed bench for axil_memory_arbiter. Inputs change and outputs are
//   sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_axil_memory_arbiter;
    import axil_memory_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] s_instr_axil_araddr;
    logic        s_instr_axil_arvalid, s_instr_axil_arready;
    logic [31:0] s_instr_axil_rdata;
    logic        s_instr_axil_rvalid, s_instr_axil_rready;

    logic [31:0] s_data_axil_araddr;
    logic        s_data_axil_arvalid, s_data_axil_arready;
    logic [31:0] s_data_axil_rdata;
    logic        s_data_axil_rvalid, s_data_axil_rready;
    logic [31:0] s_data_axil_awaddr;
    logic        s_data_axil_awvalid, s_data_axil_awready;
    logic [31:0] s_data_axil_wdata;
    logic [3:0]  s_data_axil_wstrb;
    logic        s_data_axil_wvalid, s_data_axil_wready;
    logic [1:0]  s_data_axil_bresp;
    logic        s_data_axil_bvalid, s_data_axil_bready;

    logic [31:0] m_axil_araddr;
    logic        m_axil_arvalid, m_axil_arready;
    logic [31:0] m_axil_rdata;
    logic        m_axil_rvalid, m_axil_rready;
    logic [31:0] m_axil_awaddr;
    logic        m_axil_awvalid, m_axil_awready;
    logic [31:0] m_axil_wdata;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_wvalid, m_axil_wready;
    logic [1:0]  m_axil_bresp;
    logic        m_axil_bvalid, m_axil_bready;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    axil_memory_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .i_Clock              (clk),
        .i_Reset_N            (rst_n),
        .s_instr_axil_araddr  (s_instr_axil_araddr),
        .s_instr_axil_arvalid (s_instr_axil_arvalid),
        .s_instr_axil_arready (s_instr_axil_arready),
        .s_instr_axil_rdata   (s_instr_axil_rdata),
        .s_instr_axil_rvalid  (s_instr_axil_rvalid),
        .s_instr_axil_rready  (s_instr_axil_rready),
        .s_data_axil_araddr   (s_data_axil_araddr),
        .s_data_axil_arvalid  (s_data_axil_arvalid),
        .s_data_axil_arready  (s_data_axil_arready),
        .s_data_axil_rdata    (s_data_axil_rdata),
        .s_data_axil_rvalid   (s_data_axil_rvalid),
        .s_data_axil_rready   (s_data_axil_rready),
        .s_data_axil_awaddr   (s_data_axil_awaddr),
        .s_data_axil_awvalid  (s_data_axil_awvalid),
        .s_data_axil_awready  (s_data_axil_awready),
        .s_data_axil_wdata    (s_data_axil_wdata),
        .s_data_axil_wstrb    (s_data_axil_wstrb),
        .s_data_axil_wvalid   (s_data_axil_wvalid),
        .s_data_axil_wready   (s_data_axil_wready),
        .s_data_axil_bresp    (s_data_axil_bresp),
        .s_data_axil_bvalid   (s_data_axil_bvalid),
        .s_data_axil_bready   (s_data_axil_bready),
        .m_axil_araddr        (m_axil_araddr),
        .m_axil_arvalid       (m_axil_arvalid),
        .m_axil_arready       (m_axil_arready),
        .m_axil_rdata         (m_axil_rdata),
        .m_axil_rvalid        (m_axil_rvalid),
        .m_axil_rready        (m_axil_rready),
        .m_axil_awaddr        (m_axil_awaddr),
        .m_axil_awvalid       (m_axil_awvalid),
        .m_axil_awready       (m_axil_awready),
        .m_axil_wdata         (m_axil_wdata),
        .m_axil_wstrb         (m_axil_wstrb),
        .m_axil_wvalid        (m_axil_wvalid),
        .m_axil_wready        (m_axil_wready),
        .m_axil_bresp         (m_axil_bresp),
        .m_axil_bvalid        (m_axil_bvalid),
        .m_axil_bready        (m_axil_bready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait memory: every master ready/valid held high.
    task automatic init_inputs();
        s_instr_axil_araddr  = '0;
        s_instr_axil_arvalid = 1'b0;
        s_instr_axil_rready  = 1'b1;
        s_data_axil_araddr   = '0;
        s_data_axil_arvalid  = 1'b0;
        s_data_axil_rready   = 1'b1;
        s_data_axil_awaddr   = '0;
        s_data_axil_awvalid  = 1'b0;
        s_data_axil_wdata    = '0;
        s_data_axil_wstrb    = '0;
        s_data_axil_wvalid   = 1'b0;
        s_data_axil_bready   = 1'b1;
        m_axil_arready       = 1'b1;
        m_axil_rdata         = '0;
        m_axil_rvalid        = 1'b1;
        m_axil_awready       = 1'b1;
        m_axil_wready        = 1'b1;
        m_axil_bresp         = RESP_OKAY;
        m_axil_bvalid        = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        init_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Called in the accept cycle (T0) with the request already presented.
    task automatic read_walk(input logic port, input logic [31:0] addr,
                             input logic [31:0] data, input bit drop);
        #1;
        chk("acc_instr_ar", s_instr_axil_arready, port == PORT_INSTR);
        chk("acc_data_ar", s_data_axil_arready, port == PORT_DATA);
        chk("acc_data_aw", s_data_axil_awready, 0);
        m_axil_rdata = data;
        step();
        if (drop) begin
            if (port == PORT_INSTR) s_instr_axil_arvalid = 1'b0;
            else                    s_data_axil_arvalid  = 1'b0;
        end
        chk("rd_m_arvalid", m_axil_arvalid, 1);
        chk("rd_m_araddr", m_axil_araddr, addr);
        chk("rd_busy_rdy", {s_instr_axil_arready, s_data_axil_arready, s_data_axil_awready}, 0);
        step();
        chk("rd_m_rready", m_axil_rready, 1);
        chk("rd_m_arvalid_off", m_axil_arvalid, 0);
        step();
        chk("rd_s_rvalid_i", s_instr_axil_rvalid, port == PORT_INSTR);
        chk("rd_s_rvalid_d", s_data_axil_rvalid, port == PORT_DATA);
        chk("rd_s_rdata", (port == PORT_INSTR) ? s_instr_axil_rdata : s_data_axil_rdata, data);
        chk("rd_m_rready_off", m_axil_rready, 0);
        step();
        chk("rd_done", {s_instr_axil_rvalid, s_data_axil_rvalid}, 0);
    endtask

    task automatic write_walk(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [1:0] resp);
        #1;
        chk("acc_wr_aw", s_data_axil_awready, 1);
        chk("acc_wr_w", s_data_axil_wready, 1);
        chk("acc_wr_ar", {s_instr_axil_arready, s_data_axil_arready}, 0);
        step();
        s_data_axil_awvalid = 1'b0;
        s_data_axil_wvalid  = 1'b0;
        chk("wr_m_awvalid", m_axil_awvalid, 1);
        chk("wr_m_wvalid", m_axil_wvalid, 1);
        chk("wr_m_awaddr", m_axil_awaddr, addr);
        chk("wr_m_wdata", m_axil_wdata, data);
        chk("wr_m_wstrb", m_axil_wstrb, strb);
        step();
        chk("wr_m_aw_w_off", {m_axil_awvalid, m_axil_wvalid}, 0);
        chk("wr_m_bready", m_axil_bready, 1);
        step();
        chk("wr_s_bvalid", s_data_axil_bvalid, 1);
        chk("wr_s_bresp", s_data_axil_bresp, resp);
        step();
        chk("wr_s_bvalid_off", s_data_axil_bvalid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Reset state, no requests pending.
        chk("rst_m_valids", {m_axil_arvalid, m_axil_awvalid, m_axil_wvalid}, 0);
        chk("rst_m_readies", {m_axil_rready, m_axil_bready}, 0);
        chk("rst_s_valids", {s_instr_axil_rvalid, s_data_axil_rvalid, s_data_axil_bvalid}, 0);
        chk("rst_s_readies", {s_instr_axil_arready, s_data_axil_arready,
                              s_data_axil_awready, s_data_axil_wready}, 0);
        chk("rst_addr", m_axil_araddr, 0);
        chk("rst_wdata", m_axil_wdata, 0);
        chk("rst_bresp", s_data_axil_bresp, 0);

        // Lone instruction read.
        s_instr_axil_araddr  = 32'h0000_0100;
        s_instr_axil_arvalid = 1'b1;
        read_walk(PORT_INSTR, 32'h0000_0100, 32'hDEAD_BEEF, 1);

        // Both ports reading continuously: strict alternation, instr first.
        do_reset();
        s_instr_axil_araddr  = 32'h0000_0200;
        s_data_axil_araddr   = 32'h0000_0300;
        s_instr_axil_arvalid = 1'b1;
        s_data_axil_arvalid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            read_walk((i % 2 == 0) ? PORT_INSTR : PORT_DATA,
                      (i % 2 == 0) ? 32'h0000_0200 : 32'h0000_0300,
                      32'h1000_0000 + i, 0);
        end
        s_instr_axil_arvalid = 1'b0;
        s_data_axil_arvalid  = 1'b0;

        // Write with AW accepted three cycles before W, SLVERR response.
        m_axil_awready      = 1'b0;
        m_axil_wready       = 1'b0;
        m_axil_bresp        = RESP_SLVERR;
        s_data_axil_awaddr  = 32'h0000_2000;
        s_data_axil_wdata   = 32'hA5A5_A5A5;
        s_data_axil_wstrb   = 4'b0011;
        s_data_axil_awvalid = 1'b1;
        s_data_axil_wvalid  = 1'b1;
        #1;
        chk("sw_acc_aw", s_data_axil_awready, 1);
        chk("sw_acc_w", s_data_axil_wready, 1);
        chk("sw_acc_ar", s_data_axil_arready, 0);
        step();
        s_data_axil_awvalid = 1'b0;
        s_data_axil_wvalid  = 1'b0;
        chk("sw_t1_valids", {m_axil_awvalid, m_axil_wvalid}, 2'b11);
        chk("sw_awaddr", m_axil_awaddr, 32'h0000_2000);
        chk("sw_wdata", m_axil_wdata, 32'hA5A5_A5A5);
        chk("sw_wstrb", m_axil_wstrb, 4'b0011);
        m_axil_awready = 1'b1;
        step();
        m_axil_awready = 1'b0;
        chk("sw_t2_valids", {m_axil_awvalid, m_axil_wvalid}, 2'b01);
        step();
        chk("sw_t3_valids", {m_axil_awvalid, m_axil_wvalid}, 2'b01);
        chk("sw_t3_bready", m_axil_bready, 0);
        step();
        chk("sw_t4_valids", {m_axil_awvalid, m_axil_wvalid}, 2'b01);
        m_axil_wready = 1'b1;
        step();
        m_axil_awready = 1'b1;
        chk("sw_t5_valids", {m_axil_awvalid, m_axil_wvalid}, 2'b00);
        chk("sw_t5_bready", m_axil_bready, 1);
        step();
        chk("sw_bvalid", s_data_axil_bvalid, 1);
        chk("sw_bresp", s_data_axil_bresp, RESP_SLVERR);
        step();
        chk("sw_bvalid_off1", s_data_axil_bvalid, 0);
        step();
        chk("sw_bvalid_off2", s_data_axil_bvalid, 0);
        m_axil_bresp = RESP_OKAY;

        // Data read and write pending together: read first, then write.
        s_data_axil_araddr  = 32'h0000_0400;
        s_data_axil_arvalid = 1'b1;
        s_data_axil_awaddr  = 32'h0000_3000;
        s_data_axil_wdata   = 32'h5A5A_0F0F;
        s_data_axil_wstrb   = 4'hF;
        s_data_axil_awvalid = 1'b1;
        s_data_axil_wvalid  = 1'b1;
        read_walk(PORT_DATA, 32'h0000_0400, 32'h3333_3333, 1);
        write_walk(32'h0000_3000, 32'h5A5A_0F0F, 4'hF, RESP_OKAY);

        // Upstream back-pressure in S_R with a new request waiting.
        s_instr_axil_rready  = 1'b0;
        s_instr_axil_araddr  = 32'h0000_0500;
        s_instr_axil_arvalid = 1'b1;
        m_axil_rdata         = 32'hCAFE_F00D;
        #1;
        chk("bp_acc", s_instr_axil_arready, 1);
        step();
        step();
        step();
        m_axil_rdata = 32'h0BAD_0BAD;
        for (int k = 0; k < 5; k++) begin
            chk("bp_rvalid", s_instr_axil_rvalid, 1);
            chk("bp_rdata", s_instr_axil_rdata, 32'hCAFE_F00D);
            chk("bp_no_acc", s_instr_axil_arready, 0);
            step();
        end
        s_instr_axil_rready = 1'b1;
        step();
        read_walk(PORT_INSTR, 32'h0000_0500, 32'h1234_5678, 1);

        // Reset asserted while waiting for read data.
        s_instr_axil_araddr  = 32'h0000_0600;
        s_instr_axil_arvalid = 1'b1;
        step();
        s_instr_axil_arvalid = 1'b0;
        step();
        chk("mr_rready", m_axil_rready, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_rst_readies", {m_axil_rready, m_axil_bready}, 0);
        chk("mr_rst_valids", {m_axil_arvalid, m_axil_awvalid, m_axil_wvalid,
                              s_instr_axil_rvalid, s_data_axil_rvalid, s_data_axil_bvalid}, 0);
        chk("mr_rst_addr", m_axil_araddr, 0);
        step();
        rst_n = 1'b1;
        // Last grant is back to data, so a tie must go to the instruction port.
        s_instr_axil_araddr  = 32'h0000_0600;
        s_instr_axil_arvalid = 1'b1;
        s_data_axil_araddr   = 32'h0000_0700;
        s_data_axil_arvalid  = 1'b1;
        read_walk(PORT_INSTR, 32'h0000_0600, 32'h6666_6666, 1);
        read_walk(PORT_DATA, 32'h0000_0700, 32'h7777_7777, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
